// File: rtl/mx_pkg.sv
// Shared types and constants for the MX streaming quantiser.
// BF16 field layout and the NaN-block shared exponent.
package mx_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam logic [7:0] MX_NAN_EXP = 8'hFF;

  typedef struct packed {
    logic                  sgn;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

endpackage

// File: rtl/mx_elem_quant.sv
// One BF16 element quantised to MXINT against a shared exponent.
// Shift, round half away from zero, saturate, then apply sign.
module mx_elem_quant
  import mx_pkg::*;
#(
  parameter int BIT_WIDTH = 8
) (
  input  bf16_t                elem,
  input  logic [7:0]           e_max,
  output logic [BIT_WIDTH-1:0] q
);

  localparam logic [15:0] MAXV =
    16'((1 << (BIT_WIDTH - 1)) - 1);

  logic [7:0]           mag;
  logic [7:0]           d;
  logic [8:0]           s;
  logic [15:0]          r;
  logic [BIT_WIDTH-1:0] rb;

  // Magnitude alignment, rounding and saturation
  always_comb begin
    mag = {1'b1, elem.man};
    d   = e_max - elem.exp;
    s   = 9'(d) + 9'(9 - BIT_WIDTH);
    r   = '0;
    if (elem.exp == 8'd0) begin
      r = '0;
    end else if (s == 9'd0) begin
      r = {8'h00, mag};
    end else if (s < 9'd16) begin
      r = ({8'h00, mag}
           + (16'd1 << (s[3:0] - 4'd1)))
          >> s[3:0];
    end
    if (r > MAXV) begin
      r = MAXV;
    end
    rb = r[BIT_WIDTH-1:0];
    q  = elem.sgn ? -rb : rb;
  end

endmodule

// File: rtl/mx_stream_bf16_to_mxint.sv
// Streaming BF16 to MXINT block quantiser.
// Fills one K-element block while the previous block is held.
module mx_stream_bf16_to_mxint
  import mx_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int K         = 32,
  parameter int P         = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [P-1:0][15:0]            i_bf16,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [K-1:0][BIT_WIDTH-1:0]   o_mx_vec,
  output logic [7:0]                    o_mx_exp,
  output logic                          o_nan
);

  localparam int NB = K / P;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0] cnt;
  logic          full;
  logic [7:0]    run_max;
  logic          run_nan;
  bf16_t         fill_q [K];

  logic          xfer;
  logic          move;
  logic          last;
  logic [7:0]    nxt_max;
  logic          nxt_nan;

  logic [K-1:0][BIT_WIDTH-1:0] qv;

  assign last    = (cnt == CW'(NB - 1));
  assign move    = full && (!o_valid || i_ready);
  assign o_ready = !full || move;
  assign xfer    = i_valid && o_ready;

  // Beat-level max/NaN; a beat at slot 0 starts a fresh block
  always_comb begin
    nxt_max = (cnt == '0) ? 8'd0 : run_max;
    nxt_nan = (cnt == '0) ? 1'b0 : run_nan;
    for (int l = 0; l < P; l++) begin
      if (i_bf16[l][14:7] > nxt_max) begin
        nxt_max = i_bf16[l][14:7];
      end
      if (i_bf16[l][14:7] == MX_NAN_EXP) begin
        nxt_nan = 1'b1;
      end
    end
  end

  // Beat counter, block-full flag and running statistics
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      full    <= 1'b0;
      run_max <= 8'd0;
      run_nan <= 1'b0;
    end else begin
      if (xfer) begin
        cnt     <= last ? '0 : cnt + 1'b1;
        run_max <= nxt_max;
        run_nan <= nxt_nan;
      end
      if (xfer && last) begin
        full <= 1'b1;
      end else if (move) begin
        full <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_slot
    // Fill-buffer slot written by its lane on its beat
    always_ff @(posedge i_clk) begin
      if (xfer && cnt == CW'(g / P)) begin
        fill_q[g] <= bf16_t'(i_bf16[g % P]);
      end
    end

    mx_elem_quant #(
      .BIT_WIDTH (BIT_WIDTH)
    ) u_quant (
      .elem  (fill_q[g]),
      .e_max (run_max),
      .q     (qv[g])
    );
  end

  // Output register: loaded on move, cleared on handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_mx_vec <= '0;
      o_mx_exp <= 8'd0;
      o_nan    <= 1'b0;
    end else if (move) begin
      o_valid  <= 1'b1;
      o_mx_vec <= run_nan ? '0 : qv;
      o_mx_exp <= run_nan ? MX_NAN_EXP : run_max;
      o_nan    <= run_nan;
    end else if (o_valid && i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mx_stream_bf16_to_mxint.sv
// Randomised and directed bench for the BF16 to MXINT quantiser.
// Reference model quantises whole blocks with real arithmetic.
module tb_mx_stream_bf16_to_mxint;

  localparam int BW = 8;
  localparam int K  = 32;
  localparam int P  = 8;

  typedef logic [K-1:0][BW-1:0] vec_t;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            o_ready;
  logic [P-1:0][15:0] i_bf16;
  logic            o_valid;
  logic            i_ready;
  vec_t            o_mx_vec;
  logic [7:0]      o_mx_exp;
  logic            o_nan;

  always #5 clk = ~clk;

  mx_stream_bf16_to_mxint #(
    .BIT_WIDTH (BW),
    .K         (K),
    .P         (P)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_bf16   (i_bf16),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_mx_vec (o_mx_vec),
    .o_mx_exp (o_mx_exp),
    .o_nan    (o_nan)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] inq [$];
  logic [15:0] mdl [$];
  vec_t        q_vec [$];
  logic [7:0]  q_exp [$];
  logic        q_nan [$];

  int   vprob = 100;
  int   rdy_mode = 1;
  logic acc = 1'b0;
  int   cyc = 0;
  int   last_beat_cyc = 0;
  logic lat_check = 1'b0;
  logic prev_valid = 1'b0;
  logic hold_pending = 1'b0;
  vec_t hold_vec;
  logic [7:0] hold_exp;
  logic hold_nan;
  vec_t last_vec;
  logic [7:0] last_exp;
  logic last_nan;
  int   n_blk_in = 0;
  int   n_blk_out = 0;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_block();
    int   emax = 0;
    logic nan = 1'b0;
    vec_t v = '0;
    for (int i = 0; i < K; i++) begin
      int e = int'(mdl[i][14:7]);
      if (e > emax) emax = e;
      if (e == 255) nan = 1'b1;
    end
    for (int i = 0; i < K; i++) begin
      int e = int'(mdl[i][14:7]);
      int mag = 128 + int'(mdl[i][6:0]);
      int s = emax - e + 9 - BW;
      int r = 0;
      if (!nan && e != 0 && s < 16)
        r = int'($floor(real'(mag) / (2.0 ** s) + 0.5));
      if (r > (2 ** (BW - 1)) - 1) r = (2 ** (BW - 1)) - 1;
      if (mdl[i][15]) r = -r;
      v[i] = BW'(r);
    end
    q_vec.push_back(v);
    q_exp.push_back(nan ? 8'hFF : 8'(emax));
    q_nan.push_back(nan);
    n_blk_in++;
  endfunction

  task automatic step();
    logic in_x;
    logic out_x;
    @(negedge clk);
    if (acc) begin
      for (int l = 0; l < P; l++) void'(inq.pop_front());
      i_valid = 1'b0;
      acc = 1'b0;
    end
    if (!i_valid && inq.size() >= P &&
        $urandom_range(99) < vprob) begin
      i_valid = 1'b1;
      for (int l = 0; l < P; l++) i_bf16[l] = inq[l];
    end
    if (rdy_mode == 2) i_ready = ($urandom_range(99) < 70);
    else i_ready = (rdy_mode == 1);
    #1;
    if (hold_pending) begin
      chk("hold_valid", o_valid, 1'b1);
      chk("hold_vec", o_mx_vec, hold_vec);
      chk("hold_exp", o_mx_exp, hold_exp);
      chk("hold_nan", o_nan, hold_nan);
    end
    hold_pending = o_valid && !i_ready;
    hold_vec = o_mx_vec;
    hold_exp = o_mx_exp;
    hold_nan = o_nan;
    if (o_valid && !prev_valid && lat_check) begin
      chk("latency", cyc - last_beat_cyc, 2);
      lat_check = 1'b0;
    end
    prev_valid = o_valid;
    in_x  = i_valid && o_ready;
    out_x = o_valid && i_ready;
    if (out_x) begin
      n_blk_out++;
      last_vec = o_mx_vec;
      last_exp = o_mx_exp;
      last_nan = o_nan;
      if (q_vec.size() == 0) begin
        chk("spurious_block", 1'b1, 1'b0);
      end else begin
        chk("vec", o_mx_vec, q_vec.pop_front());
        chk("exp", o_mx_exp, q_exp.pop_front());
        chk("nan", o_nan, q_nan.pop_front());
      end
    end
    @(posedge clk);
    if (in_x) begin
      acc = 1'b1;
      for (int l = 0; l < P; l++) mdl.push_back(i_bf16[l]);
      if (mdl.size() == K) begin
        model_block();
        mdl.delete();
        last_beat_cyc = cyc;
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((inq.size() > 0 || acc || q_vec.size() > 0)
           && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    i_valid = 1'b0;
    acc = 1'b0;
    inq.delete();
    @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    mdl.delete();
    q_vec.delete();
    q_exp.delete();
    q_nan.delete();
    hold_pending = 1'b0;
    prev_valid = 1'b0;
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_exp", o_mx_exp, 8'd0);
    chk("rst_nan", o_nan, 1'b0);
    chk("rst_vec", o_mx_vec, '0);
  endtask

  task automatic add_block(input logic [15:0] fill,
                           input int idx,
                           input logic [15:0] val);
    for (int i = 0; i < K; i++)
      inq.push_back(i == idx ? val : fill);
  endtask

  function automatic logic [15:0] rand_elem();
    logic [7:0] e;
    int k = $urandom_range(199);
    if (k == 0) e = 8'hFF;
    else if (k < 20) e = 8'h00;
    else if (k < 40) e = 8'($urandom_range(254, 1));
    else e = 8'($urandom_range(140, 110));
    return {1'($urandom_range(1)), e, 7'($urandom_range(127))};
  endfunction

  initial begin
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_bf16 = '0;
    do_reset();

    rdy_mode = 1;
    vprob = 100;
    lat_check = 1'b1;
    add_block(16'h3F80, 0, 16'h3F80);
    drain();
    chk("one_exp", last_exp, 8'd127);
    chk("one_e0", last_vec[0], 8'h40);
    chk("one_e31", last_vec[31], 8'h40);

    add_block(16'h3F80, 0, 16'h4000);
    drain();
    chk("two_exp", last_exp, 8'd128);
    chk("two_e0", last_vec[0], 8'h40);
    chk("two_e1", last_vec[1], 8'h20);

    add_block(16'h3F80, 5, 16'hBFC0);
    drain();
    chk("neg_e5", last_vec[5], 8'hA0);

    add_block(16'h3F80, 0, 16'h3F81);
    drain();
    chk("rnd_e0", last_vec[0], 8'h41);

    add_block(16'h3F80, 0, 16'h3FFF);
    drain();
    chk("sat_e0", last_vec[0], 8'h7F);

    add_block(16'h3F80, 0, 16'h3E00);
    drain();
    chk("d3_e0", last_vec[0], 8'h08);

    add_block(16'h3F80, 3, 16'h7F80);
    drain();
    chk("inf_nan", last_nan, 1'b1);
    chk("inf_exp", last_exp, 8'hFF);
    chk("inf_vec", last_vec, '0);
    add_block(16'h3F80, 0, 16'h3F80);
    drain();
    chk("clean_nan", last_nan, 1'b0);
    chk("clean_exp", last_exp, 8'd127);

    add_block(16'h0000, 0, 16'h0000);
    drain();
    chk("zero_exp", last_exp, 8'd0);
    chk("zero_vec", last_vec, '0);

    rdy_mode = 0;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < K; i++) inq.push_back(rand_elem());
    for (int c = 0; c < 14; c++) step();
    #1;
    chk("bp_ready", o_ready, 1'b0);
    chk("bp_valid", o_valid, 1'b1);
    rdy_mode = 1;
    drain();

    rdy_mode = 1;
    add_block(16'h4000, 0, 16'h4000);
    begin
      int n = 0;
      while (mdl.size() < 2 * P && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) chk("part_timeout", 1'b0, 1'b1);
    end
    do_reset();
    add_block(16'h3F80, 2, 16'h3F81);
    drain();
    chk("post_rst_e2", last_vec[2], 8'h41);
    chk("post_rst_exp", last_exp, 8'd127);

    rdy_mode = 2;
    vprob = 75;
    for (int b = 0; b < 40; b++)
      for (int i = 0; i < K; i++) inq.push_back(rand_elem());
    drain();

    chk("block_count", n_blk_out, n_blk_in);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
